iq_gain_shift: RTL and testbench
================================

// Module: iq_gain_shift
// PURPOSE
//   Digital AGC gain stage downstream of rssi_shift: applies its num_shift (0..4) as an arithmetic
//   left shift to the baseband I/Q stream with saturation. Shift changes are slewed one step at a
//   time, rate-limited, and frozen while a packet is in flight, so gain never jumps mid-packet.
//   Sits between the ADC/DDC sample path and the receiver demodulator.
// PARAMETERS
//   DATA_WIDTH  16    width of signed I and Q samples (in and out)
//   MAX_SHIFT   4     largest shift applied; requested values above it are clamped
//   STEP_HOLD   1024  min clk cycles between successive 1-step shift changes (>=1)
// PORTS
//   clk              in   1           system clock, 100 MHz
//   reset            in   1           synchronous, active-high reset
//   num_shift        in   3           requested shift from rssi_shift (0..7 accepted, clamped)
//   pkt_busy         in   1           high while a packet is being received; freezes shift
//   data_in_i        in   DATA_WIDTH  signed I sample
//   data_in_q        in   DATA_WIDTH  signed Q sample
//   data_in_valid    in   1           sample qualifier
//   data_out_i       out  DATA_WIDTH  shifted, saturated I
//   data_out_q       out  DATA_WIDTH  shifted, saturated Q
//   data_out_valid   out  1           output qualifier
//   cur_shift        out  3           shift currently applied
//   sat_pulse        out  1           1-cycle pulse, aligned with data_out_valid, if I or Q clipped
//   sat_count        out  16          saturating count of clipped samples since reset
// BEHAVIOUR
//   Reset (sync, reset=1 at clk edge): data_out_i/q=0, data_out_valid=0, cur_shift=0, sat_pulse=0,
//     sat_count=0, hold counter=0, FSM=IDLE. In-flight pipeline samples are discarded.
//   Datapath: 2-stage pipeline, latency exactly 2 cycles, no backpressure, valid-gaps preserved.
//     S1: register sample sign-extended to DATA_WIDTH+MAX_SHIFT, left-shifted by cur_shift as seen
//         in the cycle data_in_valid is high. S2: saturate to DATA_WIDTH.
//     Saturation: >2^(W-1)-1 -> 2^(W-1)-1; <-2^(W-1) -> -2^(W-1). I and Q independent.
//     sat_pulse=1 if either clipped; sat_count +1 per such sample (not per component), holds 0xFFFF.
//     data_out_i/q hold last value when data_out_valid=0.
//   Target: target = (num_shift > MAX_SHIFT) ? MAX_SHIFT : num_shift, evaluated every cycle.
//   Shift FSM:
//     IDLE : cur_shift==target or pkt_busy=1 -> stay. Else if hold counter==0 -> STEP.
//     STEP : one cycle; cur_shift +/-1 toward target; hold counter <= STEP_HOLD-1; -> HOLD.
//     HOLD : counter decrements every cycle (also while pkt_busy); at 0 -> IDLE.
//     pkt_busy=1 in IDLE blocks entry to STEP; pkt_busy rising in the same cycle as IDLE->STEP
//       decision wins (no step). A STEP already entered completes.
//     Target change during HOLD: new target used on return to IDLE; no extra step.
//   Slew: full 0->4 swing takes 4 steps, >= 3*STEP_HOLD+4 cycles.
//   cur_shift changes on clk edge after STEP; a sample entering that same cycle uses old shift.
// TESTING
//   1 reset mid-stream with valid samples in pipeline -> next 2 cycles data_out_valid=0, all outputs 0.
//   2 num_shift=2 held, pkt_busy=0, STEP_HOLD=8, in I=100,Q=-100 -> cur_shift 0->1->2 spaced 8+ cycles;
//     final out I=400,Q=-400 exactly 2 cycles after input valid.
//   3 cur_shift=4, in I=0x1000, Q=0x8000 -> out I=0x7FFF, Q=0x8000, sat_pulse=1, sat_count +1 (once).
//   4 num_shift=7 -> target clamps to 4, cur_shift never exceeds 4.
//   5 pkt_busy=1 while num_shift 0->3 -> cur_shift stays 0; pkt_busy falls -> stepping starts next cycle.
//   6 force 70000 clipped samples -> sat_count stops at 0xFFFF; num_shift 4->0 ramps down one per step.

Source files
------------

// File: rtl/iq_gain_shift.sv
// iq_gain_shift: AGC gain stage. Applies a slewed, rate-limited arithmetic
// left shift to a signed I/Q sample stream and saturates the result.
//
// Stream handshake: data_in_valid qualifies data_in_i/q in the cycle it is
// high. There is no ready/backpressure. Every accepted sample appears on
// data_out_i/q with data_out_valid exactly two cycles later. Gaps in the
// valid pattern are reproduced unchanged on the output side.
module iq_gain_shift #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_SHIFT  = 4,
  parameter int STEP_HOLD  = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   num_shift,
  input  logic                         pkt_busy,
  input  logic signed [DATA_WIDTH-1:0] data_in_i,
  input  logic signed [DATA_WIDTH-1:0] data_in_q,
  input  logic                         data_in_valid,
  output logic signed [DATA_WIDTH-1:0] data_out_i,
  output logic signed [DATA_WIDTH-1:0] data_out_q,
  output logic                         data_out_valid,
  output logic [2:0]                   cur_shift,
  output logic                         sat_pulse,
  output logic [15:0]                  sat_count,
  output logic [1:0]                   fsm_state
);

  localparam int EW = DATA_WIDTH + MAX_SHIFT;
  localparam int HW = (STEP_HOLD > 1) ? $clog2(STEP_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(STEP_HOLD - 1);
  localparam logic [2:0] MAX_SHIFT_3 = 3'(MAX_SHIFT);
  localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = -(EW'(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [2:0]    shift_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [2:0]    target;

  logic signed [EW-1:0] s1_i, s1_q;
  logic                 s1_valid;

  logic                         clip_i, clip_q;
  logic signed [DATA_WIDTH-1:0] sat_i, sat_q;

  assign fsm_state = state;

  // Requested shift clamped to the largest shift the datapath supports.
  always_comb begin
    target = (num_shift > MAX_SHIFT_3) ? MAX_SHIFT_3 : num_shift;
  end

  // Shift FSM state, applied shift and step hold-off counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_shift <= 3'd0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      cur_shift <= shift_n;
      hold_cnt  <= hold_n;
    end
  end

  // Next-state logic: step one unit toward the target, then hold off for
  // STEP_HOLD cycles. A busy packet only blocks leaving IDLE, so a step that
  // has already started always completes and the hold-off keeps counting.
  always_comb begin
    state_n = state;
    shift_n = cur_shift;
    hold_n  = hold_cnt;
    case (state)
      IDLE: begin
        if ((cur_shift != target) && !pkt_busy && (hold_cnt == '0)) begin
          state_n = STEP;
        end
      end
      STEP: begin
        if (target > cur_shift) begin
          shift_n = cur_shift + 3'd1;
        end else if (target < cur_shift) begin
          shift_n = cur_shift - 3'd1;
        end
        hold_n  = HOLD_INIT;
        state_n = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_n = IDLE;
        end else begin
          hold_n = hold_cnt - HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        hold_n  = '0;
      end
    endcase
  end

  // Stage 1: sign-extend and shift by the gain in force this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_i     <= '0;
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= data_in_valid;
      if (data_in_valid) begin
        s1_i <= {{MAX_SHIFT{data_in_i[DATA_WIDTH-1]}}, data_in_i} <<< cur_shift;
        s1_q <= {{MAX_SHIFT{data_in_q[DATA_WIDTH-1]}}, data_in_q} <<< cur_shift;
      end
    end
  end

  // Clip each component independently to the output range.
  always_comb begin
    clip_i = 1'b0;
    clip_q = 1'b0;
    sat_i  = s1_i[DATA_WIDTH-1:0];
    sat_q  = s1_q[DATA_WIDTH-1:0];
    if (s1_i > SAT_MAX) begin
      clip_i = 1'b1;
      sat_i  = SAT_MAX[DATA_WIDTH-1:0];
    end else if (s1_i < SAT_MIN) begin
      clip_i = 1'b1;
      sat_i  = SAT_MIN[DATA_WIDTH-1:0];
    end
    if (s1_q > SAT_MAX) begin
      clip_q = 1'b1;
      sat_q  = SAT_MAX[DATA_WIDTH-1:0];
    end else if (s1_q < SAT_MIN) begin
      clip_q = 1'b1;
      sat_q  = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // Stage 2: register saturated output; data holds while not valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_i     <= '0;
      data_out_q     <= '0;
      data_out_valid <= 1'b0;
      sat_pulse      <= 1'b0;
      sat_count      <= 16'd0;
    end else begin
      data_out_valid <= s1_valid;
      sat_pulse      <= s1_valid && (clip_i || clip_q);
      if (s1_valid) begin
        data_out_i <= sat_i;
        data_out_q <= sat_q;
        if ((clip_i || clip_q) && (sat_count != 16'hFFFF)) begin
          sat_count <= sat_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iq_gain_shift.sv
// Directed testbench for iq_gain_shift with a short step hold-off.
module tb_iq_gain_shift;

  localparam int W = 16;
  localparam int STEP_HOLD = 8;

  logic                clk;
  logic                reset;
  logic [2:0]          num_shift;
  logic                pkt_busy;
  logic signed [W-1:0] data_in_i, data_in_q;
  logic                data_in_valid;
  logic signed [W-1:0] data_out_i, data_out_q;
  logic                data_out_valid;
  logic [2:0]          cur_shift;
  logic                sat_pulse;
  logic [15:0]         sat_count;
  logic [1:0]          fsm_state;

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];

  iq_gain_shift #(.DATA_WIDTH(W), .MAX_SHIFT(4), .STEP_HOLD(STEP_HOLD)) dut (
    .clk(clk), .reset(reset), .num_shift(num_shift), .pkt_busy(pkt_busy),
    .data_in_i(data_in_i), .data_in_q(data_in_q), .data_in_valid(data_in_valid),
    .data_out_i(data_out_i), .data_out_q(data_out_q), .data_out_valid(data_out_valid),
    .cur_shift(cur_shift), .sat_pulse(sat_pulse), .sat_count(sat_count),
    .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watch cur_shift for a number of cycles, recording step direction and spacing.
  task automatic monitor_shift(input int cycles, input int dir, output int n_chg,
                               output int bad_step, output int bad_gap, output int max_seen);
    logic [2:0] prev;
    int last_t;
    prev = cur_shift; last_t = -1; n_chg = 0; bad_step = 0; bad_gap = 0;
    max_seen = int'(cur_shift);
    for (int t = 0; t < cycles; t++) begin
      tick();
      if (int'(cur_shift) > max_seen) max_seen = int'(cur_shift);
      if (cur_shift !== prev) begin
        if (int'(cur_shift) != int'(prev) + dir) bad_step++;
        if (last_t >= 0 && (t - last_t) < STEP_HOLD) bad_gap++;
        last_t = t;
        n_chg++;
        prev = cur_shift;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; num_shift = 3'd0; pkt_busy = 1'b0;
    data_in_i = '0; data_in_q = '0; data_in_valid = 1'b0;
    tick(); tick();
    checks++;
    if (data_out_valid !== 1'b0 || data_out_i !== 16'sd0 || data_out_q !== 16'sd0) begin
      errors++;
      $display("FAIL reset_data: valid=%0b i=%0d q=%0d required 0 0 0", data_out_valid, data_out_i, data_out_q);
    end
    checks++;
    if (cur_shift !== 3'd0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_fsm: shift=%0d state=%0d required 0 0", cur_shift, fsm_state);
    end
    checks++;
    if (sat_pulse !== 1'b0 || sat_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_sat: pulse=%0b count=%0d required 0 0", sat_pulse, sat_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_ramp_up();
    int n, bs, bg, mx;
    num_shift = 3'd2;
    monitor_shift(120, 1, n, bs, bg, mx);
    checks++;
    if (n != 2 || cur_shift !== 3'd2) begin
      errors++;
      $display("FAIL ramp_up_steps: changes=%0d shift=%0d required 2 2", n, cur_shift);
    end
    checks++;
    if (bs != 0 || bg != 0 || mx != 2) begin
      errors++;
      $display("FAIL ramp_up_slew: bad_step=%0d bad_gap=%0d max=%0d required 0 0 2", bs, bg, mx);
    end
    data_in_i = 16'sd100; data_in_q = -16'sd100; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    checks++;
    if (data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: valid=%0b required 0", data_out_valid);
    end
    tick();
    checks++;
    if (data_out_valid !== 1'b1 || data_out_i !== 16'sd400 || data_out_q !== -16'sd400 || sat_pulse !== 1'b0) begin
      errors++;
      $display("FAIL gain_x4: valid=%0b i=%0d q=%0d pulse=%0b required 1 400 -400 0",
               data_out_valid, data_out_i, data_out_q, sat_pulse);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [W-1:0] vi[4], vq[4], ei[4], eq[4];
    logic vv[4], ep[4];
    logic signed [W-1:0] hold_i, hold_q;
    logic [32:0] e;
    logic exp_v;
    vv[0] = 1; vi[0] = -16'sd5;   vq[0] = 16'sd3;     ei[0] = -16'sd20;  eq[0] = 16'sd12;     ep[0] = 0;
    vv[1] = 0; vi[1] = 16'sd777;  vq[1] = 16'sd777;   ei[1] = 16'sd0;    eq[1] = 16'sd0;      ep[1] = 0;
    vv[2] = 1; vi[2] = 16'sd8192; vq[2] = -16'sd8192; ei[2] = 16'sh7FFF; eq[2] = 16'sh8000;   ep[2] = 1;
    vv[3] = 1; vi[3] = -16'sd8193; vq[3] = 16'sd0;    ei[3] = 16'sh8000; eq[3] = 16'sd0;      ep[3] = 1;
    hold_i = data_out_i; hold_q = data_out_q;
    for (int j = 0; j < 5; j++) begin
      if (j < 4) begin
        data_in_i = vi[j]; data_in_q = vq[j]; data_in_valid = vv[j];
        if (vv[j]) exp_q.push_back({ep[j], ei[j], eq[j]});
      end else begin
        data_in_valid = 1'b0;
      end
      tick();
      exp_v = (j >= 1) ? vv[j-1] : 1'b0;
      checks++;
      if (data_out_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: valid=%0b required %0b", j, data_out_valid, exp_v);
      end else if (exp_v && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({sat_pulse, data_out_i, data_out_q} !== e) begin
          errors++;
          $display("FAIL b2b_data[%0d]: pulse=%0b i=%0d q=%0d required %0b %0d %0d", j,
                   sat_pulse, data_out_i, data_out_q, e[32], $signed(e[31:16]), $signed(e[15:0]));
        end
        hold_i = data_out_i; hold_q = data_out_q;
      end else if (!exp_v) begin
        checks++;
        if (data_out_i !== hold_i || data_out_q !== hold_q || sat_pulse !== 1'b0) begin
          errors++;
          $display("FAIL b2b_hold[%0d]: i=%0d q=%0d pulse=%0b required %0d %0d 0",
                   j, data_out_i, data_out_q, sat_pulse, hold_i, hold_q);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || sat_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_drain: left=%0d count=%0d required 0 2", exp_q.size(), sat_count);
    end
  endtask

  task automatic test_clamp();
    int n, bs, bg, mx;
    num_shift = 3'd7;
    monitor_shift(120, 1, n, bs, bg, mx);
    checks++;
    if (cur_shift !== 3'd4 || mx != 4 || n != 2) begin
      errors++;
      $display("FAIL clamp: shift=%0d max=%0d changes=%0d required 4 4 2", cur_shift, mx, n);
    end
    checks++;
    if (bs != 0 || bg != 0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL clamp_slew: bad_step=%0d bad_gap=%0d state=%0d required 0 0 0", bs, bg, fsm_state);
    end
  endtask

  task automatic test_saturate();
    data_in_i = 16'sh1000; data_in_q = 16'sh8000; data_in_valid = 1'b1;
    tick();
    data_in_i = 16'sh07FF; data_in_q = -16'sd2048;
    tick();
    data_in_valid = 1'b0;
    checks++;
    if (data_out_i !== 16'sh7FFF || data_out_q !== 16'sh8000 || sat_pulse !== 1'b1 || sat_count !== 16'd3) begin
      errors++;
      $display("FAIL sat_clip: i=%h q=%h pulse=%0b count=%0d required 7fff 8000 1 3",
               data_out_i, data_out_q, sat_pulse, sat_count);
    end
    tick();
    checks++;
    if (data_out_i !== 16'sh7FF0 || data_out_q !== 16'sh8000 || sat_pulse !== 1'b0 || sat_count !== 16'd3) begin
      errors++;
      $display("FAIL sat_edge: i=%h q=%h pulse=%0b count=%0d required 7ff0 8000 0 3",
               data_out_i, data_out_q, sat_pulse, sat_count);
    end
  endtask

  task automatic test_sat_count();
    int n, bs, bg, mx;
    data_in_i = 16'sh7FFF; data_in_q = 16'sd0; data_in_valid = 1'b1;
    for (int k = 0; k < 70000; k++) tick();
    checks++;
    if (sat_pulse !== 1'b1 || data_out_i !== 16'sh7FFF) begin
      errors++;
      $display("FAIL sat_stream: pulse=%0b i=%h required 1 7fff", sat_pulse, data_out_i);
    end
    data_in_valid = 1'b0;
    tick(); tick();
    checks++;
    if (sat_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_count_cap: count=%h required ffff", sat_count);
    end
    num_shift = 3'd0;
    monitor_shift(120, -1, n, bs, bg, mx);
    checks++;
    if (n != 4 || cur_shift !== 3'd0 || bs != 0 || bg != 0) begin
      errors++;
      $display("FAIL ramp_down: changes=%0d shift=%0d bad_step=%0d bad_gap=%0d required 4 0 0 0",
               n, cur_shift, bs, bg);
    end
  endtask

  task automatic test_pkt_busy();
    int moved;
    moved = 0;
    pkt_busy = 1'b1; num_shift = 3'd3;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (cur_shift !== 3'd0 || fsm_state !== 2'd0) moved++;
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL busy_freeze: moved_cycles=%0d required 0", moved);
    end
    pkt_busy = 1'b0;
    tick();
    checks++;
    if (fsm_state !== 2'd1 || cur_shift !== 3'd0) begin
      errors++;
      $display("FAIL busy_release: state=%0d shift=%0d required 1 0", fsm_state, cur_shift);
    end
    tick();
    checks++;
    if (fsm_state !== 2'd2 || cur_shift !== 3'd1) begin
      errors++;
      $display("FAIL busy_first_step: state=%0d shift=%0d required 2 1", fsm_state, cur_shift);
    end
    pkt_busy = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    checks++;
    if (fsm_state !== 2'd0 || cur_shift !== 3'd1) begin
      errors++;
      $display("FAIL busy_hold_expire: state=%0d shift=%0d required 0 1", fsm_state, cur_shift);
    end
    pkt_busy = 1'b0;
  endtask

  task automatic test_reset_midstream();
    data_in_i = 16'sd1234; data_in_q = -16'sd42; data_in_valid = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; data_in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (data_out_valid !== 1'b0 || data_out_i !== 16'sd0 || data_out_q !== 16'sd0 ||
          sat_pulse !== 1'b0 || sat_count !== 16'd0 || cur_shift !== 3'd0) begin
        errors++;
        $display("FAIL reset_flush[%0d]: valid=%0b i=%0d q=%0d pulse=%0b count=%0d shift=%0d required all 0",
                 k, data_out_valid, data_out_i, data_out_q, sat_pulse, sat_count, cur_shift);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_back_to_back();
    test_clamp();
    test_saturate();
    test_sat_count();
    test_pkt_busy();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
